// File: rtl/counter_pkg.sv
// Shared counter definitions used by the up/down counters and the display path.
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH = 8;

    typedef logic [COUNTER_WIDTH-1:0] count_t;

    // Action taken by the counter on the next active edge.
    typedef enum logic [2:0] {
        OP_IDLE,
        OP_LOAD,
        OP_DEC,
        OP_RELOAD,
        OP_PARK
    } op_t;

    // Resolve the per-edge action; load outranks enable, and a zero count
    // either reloads or parks depending on auto_reload.
    function automatic op_t select_op(
        input logic load,
        input logic enable,
        input logic is_zero,
        input logic auto_reload
    );
        op_t op;
        if (load)
            op = OP_LOAD;
        else if (!enable)
            op = OP_IDLE;
        else if (!is_zero)
            op = OP_DEC;
        else if (auto_reload)
            op = OP_RELOAD;
        else
            op = OP_PARK;
        return op;
    endfunction

endpackage

// File: rtl/t_flip_flop_rn.sv
// T flip-flop with asynchronous active-low clear.
module t_flip_flop_rn (
    input  logic clock,
    input  logic resetn,
    input  logic t,
    output logic q
);

    // Toggle on a rising edge when t is high; clear immediately on reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/down_counter8.sv
// Loadable down counter with terminal-count pulse and optional auto-reload,
// built from T flip-flops so every update is expressed as a toggle mask.
module down_counter8
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done
);

    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] borrow;
    logic             done_next;
    op_t              op;

    assign zero = (count == '0);
    assign op   = select_op(load, enable, zero, auto_reload);

    // Borrow chain: bit i flips on a decrement when every lower bit is 0.
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++)
            borrow[i] = borrow[i-1] & ~count[i-1];
    end

    // Toggle mask per action; load and reload flip exactly the differing bits.
    always_comb begin
        toggle    = '0;
        done_next = 1'b0;
        unique case (op)
            OP_LOAD:   toggle = count ^ load_value;
            OP_DEC: begin
                toggle    = borrow;
                done_next = (count == WIDTH'(1));
            end
            OP_RELOAD: toggle = count ^ reload_reg;
            OP_PARK:   toggle = '0;
            OP_IDLE:   toggle = '0;
            default:   toggle = '0;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        t_flip_flop_rn u_tff (
            .clock  (clock),
            .resetn (resetn),
            .t      (toggle[g]),
            .q      (count[g])
        );
    end

    // Capture the reload value on every load.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            reload_reg <= '0;
        else if (op == OP_LOAD)
            reload_reg <= load_value;
    end

    // One-cycle pulse on the 1 -> 0 decrement only.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            done <= 1'b0;
        else
            done <= done_next;
    end

endmodule

// File: tb/tb_down_counter8.sv
module tb_down_counter8;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic       load;
    logic [7:0] load_value;
    logic       auto_reload;
    logic [7:0] count;
    logic       zero;
    logic       done;

    int unsigned vectors;
    int unsigned miscompares;

    down_counter8 #(.WIDTH(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .count       (count),
        .zero        (zero),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; auto_reload = 1'b0;
        #3;
        vectors++;
        if (count !== 8'd0 || zero !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d zero=%b done=%b, need 0/1/0", count, zero, done);
        end
        step();
        #2 resetn = 1'b1;
        step();
        vectors++;
        if (count !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: count=%0d done=%b, need 0/0", count, done);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; load_value = 8'd50; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        repeat (10) step();
        vectors++;
        if (count !== 8'd40) begin
            miscompares++;
            $display("FAIL mid_count: count=%0d, need 40", count);
        end
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if (count !== 8'd0 || zero !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d zero=%b done=%b, need 0/1/0", count, zero, done);
        end
        resetn = 1'b1; enable = 1'b0;
        step();
    endtask

    task automatic test_single_countdown();
        logic [7:0] exp_count [8] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_done  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        auto_reload = 1'b0; load = 1'b1; load_value = 8'd5; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (count !== exp_count[i] || done !== exp_done[i] || zero !== (exp_count[i] == 8'd0)) begin
                miscompares++;
                $display("FAIL single_countdown[%0d]: count=%0d done=%b zero=%b, need %0d/%b", i, count, done, zero, exp_count[i], exp_done[i]);
            end
            if (i < 7) step();
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_auto_reload();
        logic [7:0] exp_count [12] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        int pulses;
        pulses = 0;
        auto_reload = 1'b1; load = 1'b1; load_value = 8'd3;
        step();
        vectors++;
        if (count !== 8'd3) begin
            miscompares++;
            $display("FAIL reload_load: count=%0d, need 3", count);
        end
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) pulses++;
            vectors++;
            if (count !== exp_count[i] || done !== (exp_count[i] == 8'd0)) begin
                miscompares++;
                $display("FAIL auto_reload[%0d]: count=%0d done=%b, need %0d/%b", i, count, done, exp_count[i], exp_count[i] == 8'd0);
            end
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL reload_pulses: got %0d, need 3", pulses);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_priority_full_range();
        int pulses;
        pulses = 0;
        auto_reload = 1'b0; load = 1'b1; enable = 1'b1; load_value = 8'hFF;
        step();
        vectors++;
        if (count !== 8'hFF || done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_priority: count=%0h done=%b, need ff/0", count, done);
        end
        load = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (count !== 8'd0 || done !== 1'b1 || pulses != 1) begin
            miscompares++;
            $display("FAIL full_range: count=%0d done=%b pulses=%0d, need 0/1/1", count, done, pulses);
        end
        repeat (3) step();
        vectors++;
        if (count !== 8'd0 || done !== 1'b0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL no_wrap: count=%0h done=%b zero=%b, need 0/0/1", count, done, zero);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_load_zero();
        int pulses;
        pulses = 0;
        auto_reload = 1'b1; load = 1'b1; load_value = 8'd0; enable = 1'b0;
        step();
        if (done === 1'b1) pulses++;
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (count !== 8'd0 || zero !== 1'b1 || pulses != 0) begin
            miscompares++;
            $display("FAIL load_zero: count=%0d zero=%b pulses=%0d, need 0/1/0", count, zero, pulses);
        end
        enable = 1'b0; auto_reload = 1'b0;
        step();
    endtask

    task automatic test_gating();
        load = 1'b1; load_value = 8'd2; enable = 1'b0;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (count !== 8'd2 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL gated_hold[%0d]: count=%0d done=%b, need 2/0", i, count, done);
            end
        end
        enable = 1'b1;
        step();
        vectors++;
        if (count !== 8'd1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL regate_1: count=%0d done=%b, need 1/0", count, done);
        end
        step();
        vectors++;
        if (count !== 8'd0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL regate_0: count=%0d done=%b, need 0/1", count, done);
        end
        step();
        vectors++;
        if (count !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL regate_park: count=%0d done=%b, need 0/0", count, done);
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_load_during_done();
        auto_reload = 1'b0; load = 1'b1; load_value = 8'd1; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        vectors++;
        if (count !== 8'd0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_load_done: count=%0d done=%b, need 0/1", count, done);
        end
        load = 1'b1; load_value = 8'd7;
        step();
        vectors++;
        if (count !== 8'd7 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_in_done: count=%0d done=%b, need 7/0", count, done);
        end
        load = 1'b0; auto_reload = 1'b1;
        step();
        vectors++;
        if (count !== 8'd6 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL after_load_dec: count=%0d done=%b, need 6/0", count, done);
        end
        enable = 1'b0;
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_reset_mid();
        test_single_countdown();
        test_auto_reload();
        test_priority_full_range();
        test_load_zero();
        test_gating();
        test_load_during_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter8.md
# down_counter8

Loadable 8-bit synchronous down counter with terminal-count detection and optional auto-reload. It is the counting-down companion to the lab's 8-bit T-flip-flop up counter. It is used as a countdown timer and rate divider: the count feeds the HEX display path, and `done` paces downstream logic. It is built from the same T-flip-flop style, extended with a parallel load and an asynchronous active-low clear.

## Interface
- `WIDTH`, default 8: counter width in bits. All ports below marked WIDTH use this value.
- `clock` input, 1 bit: single clock. Rising edge active.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: count-down enable, sampled on the rising edge.
- `load` input, 1 bit: synchronous parallel load.
- `load_value` input, WIDTH bits: value written to `count` and to the reload register when `load` is high.
- `auto_reload` input, 1 bit: at 0 with `enable` high, 1 = reload the stored value, 0 = hold at 0.
- `count` output, WIDTH bits: current counter value.
- `zero` output, 1 bit: combinational `count == 0`.
- `done` output, 1 bit: registered one-cycle terminal-count pulse.

## Operation
- Internal state:
  - `count` register, WIDTH bits.
  - `reload_reg`, WIDTH bits, holds the last value loaded.
  - `done` register, 1 bit.
- Per-edge priority, highest first:
  1. `load`: `count <= load_value`, `reload_reg <= load_value`, `done <= 0`. Load wins over `enable`.
  2. `enable && count != 0`: `count <= count - 1`. `done <= 1` only if `count == 1`, otherwise `done <= 0`.
  3. `enable && count == 0 && auto_reload`: `count <= reload_reg`, `done <= 0`.
  4. `enable && count == 0 && !auto_reload`: `count` holds at 0, `done <= 0`. The counter never wraps to 8'hFF.
  5. `!enable`: `count` and `reload_reg` hold, `done <= 0`.
- `done` fires once per 1→0 transition, never for a load of 0, and never while parked at 0.
- Auto-reload with `reload_reg = N` (N > 0): sequence is N, N-1, …, 1, 0, N, … This gives a period of N+1 enabled cycles and exactly one `done` per period.
- Auto-reload with `reload_reg = 0`: `count` stays at 0 and `done` is never asserted.
- `auto_reload` is sampled only at `count == 0`. Changing it mid-count has no effect until then.

## Timing
- Reset: while `resetn` is low, asynchronously `count = 0`, `reload_reg = 0`, `done = 0`, and therefore `zero = 1`. Reset is effective immediately, including mid-count.
- First active edge is the first rising edge after `resetn` deasserts.
- Latency:
  - `load` → new `count` visible one edge later.
  - Decrement → `count` updates on the same edge that samples `enable`.
  - `done` is asserted in the same cycle that `count` first reads 0, and is high for exactly one clock.
- `zero` is combinational from `count`, so it has no added latency.
- `load` and `enable` both high: the load is taken and no decrement occurs that cycle.
- A load during the `done` cycle is taken normally. `done` is still high for that cycle, then drops.

## Structure
- Shared package `counter_pkg`: `COUNTER_WIDTH = 8` default constant and a `count_t` typedef of that width. These are reused by the up counter and the display logic.
- Sub-module `t_flip_flop_rn`: a T flip-flop with asynchronous active-low clear. Instantiate WIDTH copies.
- Toggle input per bit:
  - Decrement: bit i toggles when the enable condition holds and all lower bits are 0 (borrow chain).
  - Load: bit i toggles when `q[i] ^ load_value[i]`.
  - Reload: bit i toggles when `q[i] ^ reload_reg[i]`.
- `reload_reg` and `done` are plain registers with asynchronous clear.

## Test plan
- Reset mid-count: load 8'd50, enable for 10 cycles, pull `resetn` low between edges → `count = 0`, `zero = 1`, `done = 0` immediately, with no clock edge needed.
- Single countdown: load 8'd5 with `auto_reload = 0`, then hold `enable` → `count` goes 5,4,3,2,1,0,0,0. `done` is high only in the first cycle at 0.
- Auto-reload divider: load 8'd3 with `auto_reload = 1`, hold `enable` for 12 cycles → `count` repeats 3,2,1,0. `done` pulses every 4 cycles, 3 pulses total.
- Priority and edge values: with `load = 1`, `enable = 1`, `load_value = 8'hFF` → `count = 8'hFF`, not 8'hFE. Then enable 255 cycles → reaches 0 with exactly one `done`. Then enable with `auto_reload = 0` → stays at 0 with no wrap.
- Load 0 and gating:
  - Load 8'd0 → `zero = 1`, `done` never asserted.
  - Load 8'd2, drop `enable` for 5 cycles → `count` holds at 2 with no pulse.
  - Re-enable → 1, 0 and `done` is asserted once.
